// File: rtl/regfile_access_ctrl_if.sv
// Debug request/response channel between a debugger (master) and regfile_access_ctrl (slave).
interface regfile_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  dbg_req_valid;
  logic                  dbg_req_ready;
  logic                  dbg_req_write;
  logic [ADDR_WIDTH-1:0] dbg_req_addr;
  logic [DATA_WIDTH-1:0] dbg_req_wdata;
  logic                  dbg_rsp_valid;
  logic                  dbg_rsp_ready;
  logic [DATA_WIDTH-1:0] dbg_rsp_data;
  logic [ADDR_WIDTH-1:0] dbg_rsp_addr;

  modport master (
    output dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_addr
  );

  modport slave (
    input  dbg_req_valid, dbg_req_write, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_addr
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the register file write port between core writeback and a halt-mode debugger.
// Define REGFILE_ACCESS_CTRL_DUMP_EN to enable the streaming register dump (dump_start/dump_busy).
module regfile_access_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_waddr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_stall,
  input  logic                  dbg_halt_req,
  output logic                  dbg_halted,
  regfile_access_ctrl_if.slave  dbg,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    RUN, DRAIN, HALTED, RSP
`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
    , DUMP
`endif
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [DATA_WIDTH-1:0] cap_data;

  // Register 0 reads as zero and swallows writes, so responses follow suit.
  always_comb begin
    cap_data = '0;
    if (dbg.dbg_req_addr != '0)
      cap_data = dbg.dbg_req_write ? dbg.dbg_req_wdata : rf_rdata;
  end

`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
  logic [ADDR_WIDTH-1:0] idx;
  always_ff @(posedge clock) begin
    if (reset)
      idx <= '0;
    else if (state == DUMP && dbg.dbg_rsp_ready)
      idx <= (idx == '1) ? '0 : idx + ADDR_WIDTH'(1);
  end
`else
  logic dump_start_unused;
  assign dump_start_unused = dump_start;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      if (state == RUN && dbg_halt_req)
        cnt <= CW'(DRAIN_CYCLES - 1);
      else if (state == DRAIN && cnt != '0)
        cnt <= cnt - CW'(1);
      if (state == HALTED && dbg.dbg_req_valid) begin
        rsp_data_q <= cap_data;
        rsp_addr_q <= dbg.dbg_req_addr;
      end
    end
  end

  // HALTED priority: debug request, then dump, then release.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:    if (dbg_halt_req) state_nx = DRAIN;
      DRAIN:  if (cnt == '0) state_nx = HALTED;
      HALTED: begin
        if (dbg.dbg_req_valid)  state_nx = RSP;
`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
        else if (dump_start)    state_nx = DUMP;
`endif
        else if (!dbg_halt_req) state_nx = RUN;
      end
      RSP:    if (dbg.dbg_rsp_ready) state_nx = HALTED;
`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
      DUMP:   if (dbg.dbg_rsp_ready && idx == '1) state_nx = HALTED;
`endif
      default: state_nx = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted so an abandoned operation emits nothing.
  always_comb begin
    core_stall        = 1'b0;
    dbg_halted        = 1'b0;
    dump_busy         = 1'b0;
    rf_we             = 1'b0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    rf_raddr          = '0;
    dbg.dbg_req_ready = 1'b0;
    dbg.dbg_rsp_valid = 1'b0;
    dbg.dbg_rsp_data  = '0;
    dbg.dbg_rsp_addr  = '0;
    if (!reset) begin
      case (state)
        RUN, DRAIN: begin
          core_stall = (state == DRAIN);
          rf_we      = core_we && (core_waddr != '0);
          rf_waddr   = core_waddr;
          rf_wdata   = core_wdata;
        end
        HALTED: begin
          core_stall        = 1'b1;
          dbg_halted        = 1'b1;
          dbg.dbg_req_ready = 1'b1;
          rf_raddr          = dbg.dbg_req_addr;
          rf_waddr          = dbg.dbg_req_addr;
          rf_wdata          = dbg.dbg_req_wdata;
          rf_we             = dbg.dbg_req_valid && dbg.dbg_req_write && (dbg.dbg_req_addr != '0);
        end
        RSP: begin
          core_stall        = 1'b1;
          dbg_halted        = 1'b1;
          dbg.dbg_rsp_valid = 1'b1;
          dbg.dbg_rsp_data  = rsp_data_q;
          dbg.dbg_rsp_addr  = rsp_addr_q;
        end
`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
        DUMP: begin
          core_stall        = 1'b1;
          dbg_halted        = 1'b1;
          dump_busy         = 1'b1;
          rf_raddr          = idx;
          dbg.dbg_rsp_valid = 1'b1;
          dbg.dbg_rsp_data  = rf_rdata;
          dbg.dbg_rsp_addr  = idx;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed + randomized bench for regfile_access_ctrl with a behavioural register-file reference.
module tb_regfile_access_ctrl;
  localparam int DW = 32, AW = 5, DC = 3, NR = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          core_we, core_stall, dbg_halt_req, dbg_halted, dump_start, dump_busy, rf_we;
  logic [AW-1:0] core_waddr, rf_waddr, rf_raddr;
  logic [DW-1:0] core_wdata, rf_wdata, rf_rdata;

  regfile_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dbg_bus ();

  regfile_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DRAIN_CYCLES(DC)) dut (
    .clock(clock), .reset(reset),
    .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_stall(core_stall), .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
    .dbg(dbg_bus.slave), .dump_start(dump_start), .dump_busy(dump_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  // Physical register file attached to the DUT.
  logic [DW-1:0] mem [NR];
  always @(posedge clock) begin
    if (reset) for (int k = 0; k < NR; k++) mem[k] <= '0;
    else if (rf_we) mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = mem[rf_raddr];

  // Reference contents derived from the architectural rules.
  logic [DW-1:0] gold [NR];
  int total = 0, bad = 0;
  int beat, cyc;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_stall"},    32'(core_stall), 0);
    chk({t, "_halted"},   32'(dbg_halted), 0);
    chk({t, "_rdy"},      32'(dbg_bus.dbg_req_ready), 0);
    chk({t, "_rvalid"},   32'(dbg_bus.dbg_rsp_valid), 0);
    chk({t, "_rdata"},    dbg_bus.dbg_rsp_data, 0);
    chk({t, "_raddr"},    32'(dbg_bus.dbg_rsp_addr), 0);
    chk({t, "_busy"},     32'(dump_busy), 0);
    chk({t, "_rf_we"},    32'(rf_we), 0);
    chk({t, "_rf_waddr"}, 32'(rf_waddr), 0);
    chk({t, "_rf_wdata"}, rf_wdata, 0);
    chk({t, "_rf_raddr"}, 32'(rf_raddr), 0);
  endtask

  // One cycle of random core writeback; fwd says whether it must reach the register file.
  task automatic core_cycle(input bit fwd, input bit stall);
    logic w; logic [AW-1:0] a; logic [DW-1:0] d;
    w = 1'($urandom); a = AW'($urandom); d = $urandom;
    core_we = w; core_waddr = a; core_wdata = d;
    #1;
    chk("core_stall", 32'(core_stall), 32'(stall));
    chk("core_halted", 32'(dbg_halted), 32'(!fwd));
    chk("core_rf_we", 32'(rf_we), 32'(fwd && w && a != 0));
    if (fwd) begin
      chk("core_rf_waddr", 32'(rf_waddr), 32'(a));
      chk("core_rf_wdata", rf_wdata, d);
    end
    chk("core_rsp_quiet", 32'(dbg_bus.dbg_rsp_valid), 0);
    tick();
    if (fwd && w && a != 0) gold[a] = d;
    core_we = 1'b0;
  endtask

  task automatic do_halt();
    core_we = 1'b0; dbg_halt_req = 1'b1;
    #1; chk("halt_pre_stall", 32'(core_stall), 0);
    tick();
    for (int k = 0; k < DC; k++) core_cycle(1'b1, 1'b1);
    #1; chk("halt_done", 32'(dbg_halted), 1);
  endtask

  // One debug transaction, holding the response for `stall` cycles before accepting it.
  task automatic dbg_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    logic [DW-1:0] e;
    e = wr ? ((a == 0) ? 0 : d) : gold[a];
    dbg_bus.dbg_req_valid = 1'b1; dbg_bus.dbg_req_write = wr;
    dbg_bus.dbg_req_addr = a; dbg_bus.dbg_req_wdata = d; dbg_bus.dbg_rsp_ready = 1'b0;
    #1;
    chk("req_ready", 32'(dbg_bus.dbg_req_ready), 1);
    chk("dbg_rf_we", 32'(rf_we), 32'(wr && a != 0));
    if (!wr) chk("dbg_rf_raddr", 32'(rf_raddr), 32'(a));
    tick();
    if (wr && a != 0) gold[a] = d;
    dbg_bus.dbg_req_valid = 1'b0; dbg_bus.dbg_req_write = 1'($urandom);
    dbg_bus.dbg_req_addr = AW'($urandom); dbg_bus.dbg_req_wdata = $urandom;
    for (int k = 0; k < stall; k++) begin
      #1;
      chk("rsp_valid_hold", 32'(dbg_bus.dbg_rsp_valid), 1);
      chk("rsp_data_hold", dbg_bus.dbg_rsp_data, e);
      chk("rsp_addr_hold", 32'(dbg_bus.dbg_rsp_addr), 32'(a));
      chk("rsp_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
      chk("rsp_rf_we", 32'(rf_we), 0);
      tick();
    end
    dbg_bus.dbg_rsp_ready = 1'b1;
    #1;
    chk("rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
    chk("rsp_data", dbg_bus.dbg_rsp_data, e);
    chk("rsp_addr", 32'(dbg_bus.dbg_rsp_addr), 32'(a));
    tick();
    dbg_bus.dbg_rsp_ready = 1'b0;
    #1;
    chk("rsp_done", 32'(dbg_bus.dbg_rsp_valid), 0);
    chk("rsp_back_ready", 32'(dbg_bus.dbg_req_ready), 1);
  endtask

  initial begin
    for (int k = 0; k < NR; k++) gold[k] = '0;
    // Reset with busy-looking inputs: everything must stay low.
    reset = 1'b1; core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hA5A5A5A5;
    dbg_halt_req = 1'b0; dump_start = 1'b0;
    dbg_bus.dbg_req_valid = 1'b1; dbg_bus.dbg_req_write = 1'b1;
    dbg_bus.dbg_req_addr = 5'd3; dbg_bus.dbg_req_wdata = 32'h1; dbg_bus.dbg_rsp_ready = 1'b0;
    tick(); tick();
    #1; chk_zero("reset");
    dbg_bus.dbg_req_valid = 1'b0; core_we = 1'b0;
    reset = 1'b0;
    tick();

    // Directed core writeback.
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEADBEEF;
    #1;
    chk("run_we5", 32'(rf_we), 1);
    chk("run_waddr5", 32'(rf_waddr), 5);
    chk("run_wdata5", rf_wdata, 32'hDEADBEEF);
    tick(); gold[5] = 32'hDEADBEEF;
    core_waddr = 5'd0;
    #1; chk("run_we0", 32'(rf_we), 0);
    tick(); core_we = 1'b0;

    for (int k = 0; k < 30; k++) core_cycle(1'b1, 1'b0);

    // Halt with the request dropped mid-drain: drain must still complete.
    dbg_halt_req = 1'b1;
    #1; chk("halt_n_stall", 32'(core_stall), 0);
    tick();
    for (int k = 0; k < DC; k++) begin
      if (k == 0) dbg_halt_req = 1'b0;
      if (k == DC - 1) dbg_halt_req = 1'b1;
      core_cycle(1'b1, 1'b1);
    end
    for (int k = 0; k < 6; k++) core_cycle(1'b0, 1'b1);

    // Directed debug accesses.
    dbg_xfer(1'b1, 5'd7, 32'h12345678, 0);
    dbg_xfer(1'b0, 5'd7, 32'h0, 0);
    dbg_xfer(1'b1, 5'd0, 32'hFF, 1);
    dbg_xfer(1'b0, 5'd0, 32'h0, 0);
    dbg_xfer(1'b0, 5'd2, 32'h0, 4);

    for (int k = 0; k < 20; k++)
      dbg_xfer(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 2)));
    for (int k = 0; k < NR; k++) dbg_xfer(1'b0, AW'(k), 32'h0, 0);

`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
    dump_start = 1'b1;
    #1; chk("dump_busy_pre", 32'(dump_busy), 0);
    tick(); dump_start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < NR && cyc < 2000) begin
      dbg_bus.dbg_rsp_ready = 1'($urandom);
      #1;
      chk("dump_busy", 32'(dump_busy), 1);
      chk("dump_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
      chk("dump_addr", 32'(dbg_bus.dbg_rsp_addr), beat);
      chk("dump_data", dbg_bus.dbg_rsp_data, gold[beat]);
      chk("dump_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
      tick();
      if (dbg_bus.dbg_rsp_ready) beat++;
      cyc++;
    end
    chk("dump_beats", beat, NR);
    dbg_bus.dbg_rsp_ready = 1'b0;
    #1;
    chk("dump_busy_post", 32'(dump_busy), 0);
    chk("dump_valid_post", 32'(dbg_bus.dbg_rsp_valid), 0);
    chk("dump_halted_post", 32'(dbg_halted), 1);
`else
    dump_start = 1'b1;
    tick(); dump_start = 1'b0; dbg_bus.dbg_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("nodump_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
      chk("nodump_busy", 32'(dump_busy), 0);
      chk("nodump_ready", 32'(dbg_bus.dbg_req_ready), 1);
      tick();
    end
    dbg_bus.dbg_rsp_ready = 1'b0;
`endif

    // Release requested while a response is pending: resume only after HALTED.
    dbg_halt_req = 1'b0;
    dbg_xfer(1'b0, 5'd7, 32'h0, 2);
    tick();
    #1;
    chk("resume_stall", 32'(core_stall), 0);
    chk("resume_halted", 32'(dbg_halted), 0);
    for (int k = 0; k < 5; k++) core_cycle(1'b1, 1'b0);

    // Reset in the middle of an operation.
    do_halt();
`ifdef REGFILE_ACCESS_CTRL_DUMP_EN
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    dbg_bus.dbg_rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1; chk("pre_rst_addr", 32'(dbg_bus.dbg_rsp_addr), k);
      tick();
    end
    #1; chk("beat10_addr", 32'(dbg_bus.dbg_rsp_addr), 10);
`else
    dbg_bus.dbg_req_valid = 1'b1; dbg_bus.dbg_req_write = 1'b0; dbg_bus.dbg_req_addr = 5'd5;
    tick(); dbg_bus.dbg_req_valid = 1'b0;
    #1; chk("pre_rst_rsp", 32'(dbg_bus.dbg_rsp_valid), 1);
    dbg_bus.dbg_rsp_ready = 1'b1;
`endif
    reset = 1'b1; dbg_halt_req = 1'b0;
    tick();
    #1; chk_zero("midrst");
    reset = 1'b0;
    for (int k = 0; k < NR; k++) gold[k] = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
      chk("post_rst_stall", 32'(core_stall), 0);
      chk("post_rst_busy", 32'(dump_busy), 0);
      chk("post_rst_rf_we", 32'(rf_we), 0);
      tick();
    end
    dbg_bus.dbg_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) core_cycle(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, register data width.
REQ-002 Parameter: ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
REQ-003 Parameter: DRAIN_CYCLES, 3, cycles core writebacks are allowed to complete after stall.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: core_we / core_waddr / core_wdata  input  1/ADDR_WIDTH/DATA_WIDTH  core writeback request.
REQ-007 Port: core_stall  output  1  freezes core fetch/issue.
REQ-008 Port: dbg_halt_req  input  1  level; debugger wants core halted.
REQ-009 Port: dbg_halted  output  1  high only in HALTED, RSP or DUMP.
REQ-010 Port: dbg_req_valid, dbg_req_ready  in/out  1  debug request handshake.
REQ-011 Port: dbg_req_write / dbg_req_addr / dbg_req_wdata  input  1/ADDR_WIDTH/DATA_WIDTH  request payload.
REQ-012 Port: dbg_rsp_valid, dbg_rsp_ready  out/in  1  response handshake.
REQ-013 Port: dbg_rsp_data / dbg_rsp_addr  output  DATA_WIDTH/ADDR_WIDTH  response payload.
REQ-014 Port: dump_start  input  1  pulse; stream all registers. dump_busy  output  1  dump in progress.
REQ-015 Port: rf_we / rf_waddr / rf_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  register file write port.
REQ-016 Port: rf_raddr  output  ADDR_WIDTH, rf_rdata  input  DATA_WIDTH  dedicated asynchronous read port.

Function
REQ-017 FSM states SHALL be RUN, DRAIN, HALTED, RSP, DUMP; transfers occur when valid and ready are both high on a clock edge.
REQ-018 RUN: core_stall=0; rf_we=core_we&&core_waddr!=0, rf_waddr/rf_wdata=core fields; dbg_halt_req=1 -> DRAIN, counter loaded with DRAIN_CYCLES-1.
REQ-019 DRAIN: core_stall=1, core writebacks still forwarded; counter decrements each cycle; at 0 -> HALTED (DRAIN lasts exactly DRAIN_CYCLES cycles); dbg_halt_req dropping in DRAIN does not abort.
REQ-020 HALTED/RSP/DUMP: core_stall=1, core_we ignored, rf driven only by debug.
REQ-021 HALTED: dbg_req_ready=1; accepted read: rf_raddr=dbg_req_addr, data captured into dbg_rsp_data same edge -> RSP.
REQ-022 Accepted write: rf_we=1 combinationally that cycle unless addr 0 (rf_we=0); response data = dbg_req_wdata (0 for addr 0) -> RSP.
REQ-023 RSP: dbg_rsp_valid=1, dbg_req_ready=0, payload stable until accepted, then -> HALTED.
REQ-024 HALTED priority: accepted dbg request > dump_start > dbg_halt_req=0 (-> RUN, core_stall drops next cycle).
REQ-025 DUMP: index from 0; rf_raddr=index, dbg_rsp_valid=1, dbg_rsp_data=rf_rdata, dbg_rsp_addr=index; index increments on each accepted beat; beat at 2**ADDR_WIDTH-1 accepted -> HALTED; index never wraps.
REQ-026 dbg_halt_req deassertion during RSP or DUMP SHALL take effect only after return to HALTED.
REQ-027 dbg_rsp_valid SHALL never be high in RUN or DRAIN; dbg_req_ready SHALL be high only in HALTED.

Reset
REQ-028 On reset: state RUN, counter 0, dump index 0, all outputs 0 (core_stall, dbg_halted, dbg_req_ready, dbg_rsp_valid, dump_busy, rf_we, data/address outputs).
REQ-029 Reset mid-DRAIN/RSP/DUMP SHALL abandon the operation with no further rf_we and no response beat.

Configuration
REQ-030 With REGFILE_ACCESS_CTRL_DUMP_EN defined: DUMP state and dump_start/dump_busy behave per REQ-025.
REQ-031 Without it: no DUMP state or index logic, dump_start ignored, dump_busy tied 0.

Verification
REQ-032 RUN: core_we=1, waddr=5, wdata=0xDEADBEEF -> rf_we=1, rf_waddr=5 same cycle; waddr=0 -> rf_we=0.
REQ-033 Halt: dbg_halt_req=1 at cycle N -> core_stall=1 from N+1, dbg_halted=1 at N+1+DRAIN_CYCLES; core_we during DRAIN still written, during HALTED dropped.
REQ-034 Halted write addr 7 data 0x12345678 then read addr 7 -> rsp data 0x12345678; write addr 0 data 0xFF -> rf_we=0, read addr 0 returns 0.
REQ-035 Backpressure: read addr 2 with dbg_rsp_ready=0 for 4 cycles -> dbg_rsp_valid held, payload stable, dbg_req_ready=0, one beat on ready.
REQ-036 Dump (macro on): dump_start in HALTED -> 32 beats addr 0..31 with matching data under random dbg_rsp_ready; dump_busy drops after beat 31; macro off -> no beats.
REQ-037 Reset asserted mid-dump at beat 10 -> next cycle state RUN, all outputs 0, no further beats.
